// File: rtl/serializer_pkg.sv
// ============================================================================
// serializer_pkg
// Shared types and defaults for the symbol serializer stages.
// Revision: 1.0
// ============================================================================
`default_nettype none

package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam int   DEFAULT_WIDTH      = 8;
  localparam logic DEFAULT_IDLE_LEVEL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/word_hold_buf.sv
// ============================================================================
// word_hold_buf
// Single-entry valid/ready holding buffer; the consumer empties it with take.
// Revision: 1.0
// ============================================================================
`default_nettype none

module word_hold_buf
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             take,
  output logic             full,
  output logic [WIDTH-1:0] rd_data
);

  logic accept;
  logic full_next;

  assign accept = wr_valid && wr_ready;

  // take and accept are mutually exclusive: take needs full, accept needs empty
  always_comb begin
    full_next = full;
    if (take) full_next = 1'b0;
    if (accept) full_next = 1'b1;
  end

  // ready is its own register so it stays low through reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full     <= 1'b0;
      wr_ready <= 1'b0;
      rd_data  <= '0;
    end else begin
      full     <= full_next;
      wr_ready <= ~full_next;
      if (accept) rd_data <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/symbol_serializer.sv
// ============================================================================
// symbol_serializer
// Serializes buffered parallel words one bit per strobe, back-to-back.
// Optional even-parity bit per word: define SYMBOL_SERIALIZER_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module symbol_serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_strobe,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_bit,
  output logic             o_bit_valid,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  ser_state_t       state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             bit_next, bit_valid_next, frame_done_next;
  logic             load, end_word, take;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_first, cur_bit;
  logic [WIDTH-1:0] hold_shifted, shreg_shifted;
`ifdef SYMBOL_SERIALIZER_PARITY_EN
  logic             parity, parity_next;
`endif

  word_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk      (i_clk),
    .reset_n  (i_reset_n),
    .wr_data  (i_data),
    .wr_valid (i_valid),
    .wr_ready (o_ready),
    .take     (take),
    .full     (hold_full),
    .rd_data  (hold_data)
  );

  // shreg always holds the bits not yet sent, next one at the leading end
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign hold_first    = hold_data[WIDTH-1];
      assign hold_shifted  = {hold_data[WIDTH-2:0], 1'b0};
      assign cur_bit       = shreg[WIDTH-1];
      assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign hold_first    = hold_data[0];
      assign hold_shifted  = {1'b0, hold_data[WIDTH-1:1]};
      assign cur_bit       = shreg[0];
      assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_next      = state;
    shreg_next      = shreg;
    cnt_next        = cnt;
    bit_next        = o_bit;
    bit_valid_next  = 1'b0;
    frame_done_next = 1'b0;
    load            = 1'b0;
    end_word        = 1'b0;
    take            = 1'b0;
`ifdef SYMBOL_SERIALIZER_PARITY_EN
    parity_next     = parity;
`endif
    if (i_strobe) begin
      case (state)
        IDLE: load = hold_full;
        SHIFT: begin
          if (cnt != CNT_LAST) begin
            bit_next       = cur_bit;
            shreg_next     = shreg_shifted;
            cnt_next       = cnt + 1'b1;
            bit_valid_next = 1'b1;
          end else begin
`ifdef SYMBOL_SERIALIZER_PARITY_EN
            state_next     = PARITY;
            bit_next       = parity;
            bit_valid_next = 1'b1;
`else
            end_word       = 1'b1;
`endif
          end
        end
`ifdef SYMBOL_SERIALIZER_PARITY_EN
        PARITY: end_word = 1'b1;
`endif
        default: state_next = IDLE;
      endcase

      if (end_word) begin
        if (hold_full) begin
          load = 1'b1;
        end else begin
          state_next      = IDLE;
          bit_next        = IDLE_LEVEL;
          frame_done_next = 1'b1;
        end
      end

      if (load) begin
        take           = 1'b1;
        state_next     = SHIFT;
        shreg_next     = hold_shifted;
        bit_next       = hold_first;
        cnt_next       = CW'(1);
        bit_valid_next = 1'b1;
`ifdef SYMBOL_SERIALIZER_PARITY_EN
        parity_next    = ^hold_data;
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      o_bit        <= IDLE_LEVEL;
      o_bit_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
`ifdef SYMBOL_SERIALIZER_PARITY_EN
      parity       <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      shreg        <= shreg_next;
      cnt          <= cnt_next;
      o_bit        <= bit_next;
      o_bit_valid  <= bit_valid_next;
      o_frame_done <= frame_done_next;
      o_busy       <= (state_next != IDLE);
`ifdef SYMBOL_SERIALIZER_PARITY_EN
      parity       <= parity_next;
`endif
    end
  end

endmodule

`default_nettype wire

// File: doc/symbol_serializer.md
# symbol_serializer

Consumes the one-cycle rate strobe produced by the clock divider stage and turns parallel data words into a serial bit stream, one bit per strobe. It sits directly downstream of the divider. It accepts words from the upstream packet logic over a valid/ready handshake into a single-entry holding buffer. Consecutive words are serialized back-to-back with no idle bit when the buffer is refilled in time.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
- IDLE_LEVEL, 1'b1, value driven on o_bit while no word is being sent

Ports:
- i_clk  in  1  single system clock
- i_reset_n  in  1  synchronous, active-low reset, sampled on posedge i_clk
- i_strobe  in  1  one-cycle bit-rate enable from the divider
- i_data  in  WIDTH  word to send
- i_valid  in  1  i_data valid
- o_ready  out  1  holding buffer empty; a word is accepted when i_valid && o_ready
- o_bit  out  1  serial output, registered
- o_bit_valid  out  1  one-cycle pulse, high in the cycle o_bit takes a new data/parity bit
- o_busy  out  1  state != IDLE
- o_frame_done  out  1  one-cycle pulse when the last bit of a word finished and no next word was held

## Operation
- Holding buffer: hold_data, hold_full. On accept: hold_data <= i_data, hold_full <= 1. o_ready = ~hold_full, driven directly from a register, with no combinational path from i_valid.
- Shift register shreg[WIDTH-1:0] and bit counter cnt (width $clog2(WIDTH+1)).
- States:
  - IDLE
  - SHIFT
  - PARITY (exists only with the macro)
- The FSM acts only in cycles where i_strobe=1. With i_strobe=0, state, shreg, cnt and o_bit hold.
- IDLE + strobe + hold_full:
  - load shreg from hold_data and clear hold_full;
  - o_bit <= first bit, cnt <= 1, o_bit_valid <= 1;
  - go to SHIFT.
- IDLE + strobe + !hold_full: no change. o_bit stays IDLE_LEVEL.
- SHIFT + strobe, cnt < WIDTH: o_bit <= next bit, cnt <= cnt+1, o_bit_valid <= 1.
- SHIFT + strobe, cnt == WIDTH:
  - macro defined: go to PARITY and send the parity bit.
  - otherwise, if hold_full: reload from hold_data seamlessly (first bit of the new word, cnt <= 1).
  - otherwise: o_bit <= IDLE_LEVEL, o_frame_done <= 1, go to IDLE.
- PARITY + strobe: same reload-or-idle decision as the cnt == WIDTH case above.
- Simultaneous accept and load in one cycle cannot occur, because the accept requires hold_full=0. A word accepted in cycle t is first visible to the FSM in cycle t+1.
- Reset (i_reset_n=0), whether idle or mid-word:
  - state=IDLE, hold_full=0, cnt=0, shreg=0;
  - o_bit=IDLE_LEVEL, o_bit_valid=0, o_frame_done=0, o_busy=0;
  - o_ready=0 during reset and 1 from the first cycle after release;
  - any held or partially sent word is discarded.

## Timing
- All outputs are registered. o_bit, o_bit_valid and o_frame_done update on the i_clk edge at which i_strobe is sampled high.
- Latency, accept to first bit: the first strobe sampled strictly after the accept cycle, plus 0 cycles.
- A word occupies exactly WIDTH strobe periods, or WIDTH+1 with parity.
- Gap-free streaming requires the next accept before the strobe that ends the current word. o_ready reasserts the cycle after a load, giving the producer WIDTH-1 strobe periods of slack.
- o_frame_done coincides with o_bit returning to IDLE_LEVEL.

## Configuration
- SYMBOL_SERIALIZER_PARITY_EN defined:
  - PARITY state compiled in;
  - an even-parity bit (XOR of all WIDTH data bits, computed at load and stored) is sent after each word;
  - o_bit_valid pulses for the parity bit as well.
- Not defined: no PARITY state, no parity register, and words are WIDTH bits back-to-back.

## Structure
- Shared package serializer_pkg:
  - ser_state_t enum (IDLE, SHIFT, PARITY);
  - localparam default WIDTH;
  - the IDLE_LEVEL default constant.
- One natural sub-module: word_hold_buf (single-entry valid/ready buffer with take/full signals), reusable by other stages.
- Bit selection (MSB_FIRST) is a generate/ternary on the shift direction inside the top module.

## Test plan
- Reset release, IDLE_LEVEL=1, no data, strobes every 4 cycles → o_bit=1 and o_bit_valid=0 throughout; o_ready=1 from the cycle after reset release.
- Single word 8'hA5 with MSB_FIRST=1 → bits 1,0,1,0,0,1,0,1 on 8 consecutive strobes, each with an o_bit_valid pulse. Then o_frame_done on the 9th strobe and o_bit=1.
- Words 8'hFF then 8'h00 with the second accepted mid-word → 16 data bits with no idle bit between words; a single o_frame_done after bit 16.
- i_valid held high while hold_full → second word not accepted until o_ready rises the cycle after the load; no word lost or duplicated.
- Reset asserted after 3 bits of 8'h3C → next cycle o_bit=IDLE_LEVEL, o_busy=0, o_ready=1 after release; the next word sent from bit 0.
- With SYMBOL_SERIALIZER_PARITY_EN, word 8'h07 → 8 data bits, then parity bit 1 on the 9th strobe, then o_frame_done on the 10th.
